// File: rtl/nn_pkg.sv
// Shared definitions for the neuron feeder slice: data width, default
// geometry, the feeder state encoding and the signed operand type.
package nn_pkg;

  localparam int DATA_W       = 8;
  localparam int N_INPUTS_DEF = 4;
  localparam int PIPE_LAT_DEF = 3;

  typedef logic signed [DATA_W-1:0] nn_data_t;

  typedef enum logic [1:0] {
    FILL   = 2'd0,
    STREAM = 2'd1,
    DRAIN  = 2'd2,
    DONE   = 2'd3
  } feeder_state_t;

  // Index width for an n-entry table; a single entry still needs one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/neuron_feeder_pair_buffer.sv
// pair_buffer: N_INPUTS x {x,w} register file. One write port (fill side)
// and one registered read port (stream side). The read register returns
// zero whenever no read is requested, so it can drive x_o/w_o directly
// and shows a clean zero operand outside of streaming.
module pair_buffer
  import nn_pkg::*;
#(
  parameter int N_INPUTS = N_INPUTS_DEF,
  localparam int IW      = idx_w(N_INPUTS)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [IW-1:0]            wr_idx,
  input  logic signed [DATA_W-1:0] wr_x,
  input  logic signed [DATA_W-1:0] wr_w,
  input  logic                     rd_en,
  input  logic [IW-1:0]            rd_idx,
  output logic signed [DATA_W-1:0] rd_x,
  output logic signed [DATA_W-1:0] rd_w
);

  logic [2*DATA_W-1:0] mem [N_INPUTS];

  // Write port: store the accepted pair at the fill index.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_idx] <= {wr_x, wr_w};
    end
  end

  // Registered read port: selected pair while streaming, zero otherwise.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_x <= '0;
      rd_w <= '0;
    end else if (rd_en) begin
      {rd_x, rd_w} <= mem[rd_idx];
    end else begin
      rd_x <= '0;
      rd_w <= '0;
    end
  end

endmodule

// File: rtl/neuron_feeder.sv
// neuron_feeder: buffers N_INPUTS x/w pairs from a valid/ready load port,
// replays them one per cycle to a neuron, waits PIPE_LAT edges, captures
// y_i and offers it on a valid/ready result port.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high; valid, once raised, holds its data until that edge; ready may
// be high before valid. clear overrides both handshakes in its cycle.
//
// Optional feature macro: NEURON_FEEDER_REUSE_EN keeps the buffer after a
// result is taken, so a start pulse replays the same pairs; new pairs need
// clear first. Without it the buffer is refilled after every result.
module neuron_feeder
  import nn_pkg::*;
#(
  parameter int N_INPUTS = N_INPUTS_DEF,
  parameter int PIPE_LAT = PIPE_LAT_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clear,
  input  logic                     start,
  input  logic                     load_valid,
  output logic                     load_ready,
  input  logic signed [DATA_W-1:0] load_x,
  input  logic signed [DATA_W-1:0] load_w,
  output logic signed [DATA_W-1:0] x_o,
  output logic signed [DATA_W-1:0] w_o,
  output logic                     mac_valid_o,
  output logic                     mac_clr_o,
  input  logic signed [DATA_W-1:0] y_i,
  output logic signed [DATA_W-1:0] result,
  output logic                     result_valid,
  input  logic                     result_ready,
  output logic                     busy,
  output logic [1:0]               dbg_state
);

  localparam int CW = $clog2(N_INPUTS + 1);
  localparam int IW = idx_w(N_INPUTS);
  localparam int LW = $clog2(PIPE_LAT + 1);

  localparam logic [CW-1:0] COUNT_FULL = CW'(N_INPUTS);
  localparam logic [CW-1:0] COUNT_LAST = CW'(N_INPUTS - 1);
  localparam logic [IW-1:0] IDX_LAST   = IW'(N_INPUTS - 1);
  localparam logic [LW-1:0] LAT_END    = LW'(PIPE_LAT - 1);

  feeder_state_t state;
  logic [CW-1:0] count;
  logic [IW-1:0] idx;
  logic [LW-1:0] lat;

  logic wr_en;
  logic rd_en;
  logic start_go;

  assign load_ready = (state == FILL) && (count < COUNT_FULL);
  assign busy       = (state != FILL);
  assign dbg_state  = state;

  assign wr_en = load_valid && load_ready && !clear;
  assign rd_en = (state == STREAM) && !clear;

`ifdef NEURON_FEEDER_REUSE_EN
  assign start_go = start && (state == FILL) && (count == COUNT_FULL);
`else
  logic unused_start;
  assign unused_start = start;
  assign start_go     = 1'b0;
`endif

  pair_buffer #(.N_INPUTS(N_INPUTS)) u_buf (
    .clk    (clk),
    .rst    (rst),
    .wr_en  (wr_en),
    .wr_idx (count[IW-1:0]),
    .wr_x   (load_x),
    .wr_w   (load_w),
    .rd_en  (rd_en),
    .rd_idx (idx),
    .rd_x   (x_o),
    .rd_w   (w_o)
  );

  // Sequencer: fill, stream, wait out neuron latency, hold result.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= FILL;
      count        <= '0;
      idx          <= '0;
      lat          <= '0;
      mac_valid_o  <= 1'b0;
      mac_clr_o    <= 1'b0;
      result       <= '0;
      result_valid <= 1'b0;
    end else if (clear) begin
      state        <= FILL;
      count        <= '0;
      idx          <= '0;
      lat          <= '0;
      mac_valid_o  <= 1'b0;
      mac_clr_o    <= 1'b0;
      result_valid <= 1'b0;
    end else begin
      case (state)
        FILL: begin
          mac_valid_o <= 1'b0;
          mac_clr_o   <= 1'b0;
          if (wr_en) begin
            count <= count + CW'(1);
            idx   <= '0;
            if (count == COUNT_LAST) begin
              state <= STREAM;
            end
          end else if (start_go) begin
            idx   <= '0;
            state <= STREAM;
          end
        end
        STREAM: begin
          mac_valid_o <= 1'b1;
          mac_clr_o   <= (idx == '0);
          if (idx == IDX_LAST) begin
            idx   <= '0;
            lat   <= '0;
            state <= DRAIN;
          end else begin
            idx <= idx + IW'(1);
          end
        end
        DRAIN: begin
          mac_valid_o <= 1'b0;
          mac_clr_o   <= 1'b0;
          if (lat == LAT_END) begin
            lat          <= '0;
            result       <= y_i;
            result_valid <= 1'b1;
            state        <= DONE;
          end else begin
            lat <= lat + LW'(1);
          end
        end
        DONE: begin
          if (result_ready) begin
            result_valid <= 1'b0;
            state        <= FILL;
`ifndef NEURON_FEEDER_REUSE_EN
            count        <= '0;
`endif
          end
        end
        default: state <= FILL;
      endcase
    end
  end

endmodule

// File: tb/tb_neuron_feeder.sv
// Bench for neuron_feeder: directed loads with hand-computed expectations,
// a scoreboard of expected pairs/results drained by a negedge monitor, and
// a second N_INPUTS=1 instance for the single-pair case.
module tb_neuron_feeder;
  import nn_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- main DUT (defaults) ----------------
  logic clear, start, load_valid, load_ready, result_ready, result_valid;
  logic mac_valid_o, mac_clr_o, busy;
  logic signed [7:0] load_x, load_w, x_o, w_o, y_i, result;
  logic [1:0] dbg_state;

  neuron_feeder u_dut (
    .clk(clk), .rst(rst), .clear(clear), .start(start),
    .load_valid(load_valid), .load_ready(load_ready),
    .load_x(load_x), .load_w(load_w), .x_o(x_o), .w_o(w_o),
    .mac_valid_o(mac_valid_o), .mac_clr_o(mac_clr_o), .y_i(y_i),
    .result(result), .result_valid(result_valid),
    .result_ready(result_ready), .busy(busy), .dbg_state(dbg_state)
  );

  // ---------------- single-pair DUT ----------------
  logic ld_valid1, ld_ready1, rr1, rv1, mv1, mc1, busy1;
  logic signed [7:0] x1, w1, xo1, wo1, y1, res1;
  logic [1:0] dbg1;

  neuron_feeder #(.N_INPUTS(1), .PIPE_LAT(3)) u_one (
    .clk(clk), .rst(rst), .clear(1'b0), .start(1'b0),
    .load_valid(ld_valid1), .load_ready(ld_ready1),
    .load_x(x1), .load_w(w1), .x_o(xo1), .w_o(wo1),
    .mac_valid_o(mv1), .mac_clr_o(mc1), .y_i(y1),
    .result(res1), .result_valid(rv1),
    .result_ready(rr1), .busy(busy1), .dbg_state(dbg1)
  );

  // ---------------- scoreboard ----------------
  int n_vec = 0;
  int n_err = 0;
  logic [16:0]       exp_q[$];
  logic signed [7:0] exp_res_q[$];
  int   e_cyc, rise_cyc;
  logic rv_prev;
  logic signed [7:0] ld_x[4], ld_w[4];

  task automatic check(input string name, input logic signed [31:0] act,
                       input logic signed [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: pops expectations whenever the DUT presents a pair or a result.
  always @(negedge clk) begin : monitor
    logic [16:0] e;
    logic signed [7:0] r;
    if (mac_valid_o) begin
      if (exp_q.size() == 0) begin
        n_vec++; n_err++;
        $display("FAIL unexpected_pair: got x=%0d w=%0d expected none", x_o, w_o);
      end else begin
        e = exp_q.pop_front();
        check("pair", {15'd0, mac_clr_o, x_o, w_o}, {15'd0, e});
      end
    end
    if (result_valid && !rv_prev) rise_cyc = cyc;
    rv_prev = result_valid;
    if (result_valid && result_ready) begin
      if (exp_res_q.size() == 0) begin
        n_vec++; n_err++;
        $display("FAIL unexpected_result: got %0d expected none", result);
      end else begin
        r = exp_res_q.pop_front();
        check("result", result, r);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_clear();
    clear = 1'b1; tick(); clear = 1'b0;
  endtask

  task automatic push_pairs(input int n);
    for (int i = 0; i < n; i++) exp_q.push_back({(i == 0), ld_x[i], ld_w[i]});
  endtask

  // Back-to-back loads of ld_x/ld_w; n_exp of them expected on the stream.
  task automatic load_pairs(input int n_exp);
    push_pairs(n_exp);
    for (int i = 0; i < 4; i++) begin
      load_valid = 1'b1; load_x = ld_x[i]; load_w = ld_w[i];
      check("load_ready_fill", load_ready, 1);
      tick();
    end
    load_valid = 1'b0;
    e_cyc = cyc;
  endtask

  // From E: stream 4 edges, then present y and expect it as the result.
  task automatic eval_tail(input logic signed [7:0] y);
    repeat (4) tick();
    y_i = y;
    exp_res_q.push_back(y);
  endtask

  task automatic wait_done();
    int i;
    for (i = 0; i < 40; i++) begin
      if (!busy && !result_valid) break;
      tick();
    end
    if (i == 40) check("wait_done_timeout", 1, 0);
  endtask

  task automatic wait_rv();
    int i;
    for (i = 0; i < 40; i++) begin
      if (result_valid) break;
      tick();
    end
    if (i == 40) check("wait_rv_timeout", 1, 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b0; clear = 0; start = 0; load_valid = 0; load_x = 0; load_w = 0;
    y_i = 0; result_ready = 1; rv_prev = 0;
    ld_valid1 = 0; x1 = 0; w1 = 0; y1 = 0; rr1 = 1;
    repeat (2) @(posedge clk);
    #1;
    // reset values
    check("rst_load_ready", load_ready, 1);
    check("rst_mac_valid", mac_valid_o, 0);
    check("rst_mac_clr", mac_clr_o, 0);
    check("rst_x_o", x_o, 0);
    check("rst_w_o", w_o, 0);
    check("rst_result", result, 0);
    check("rst_result_valid", result_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_state", dbg_state, FILL);
    rst = 1'b1;
    tick();

    // basic evaluation, result_ready held high before DONE
    ld_x = '{8'sd1, 8'sd3, 8'sd5, 8'sd7};
    ld_w = '{8'sd2, 8'sd4, 8'sd6, 8'sd8};
    load_pairs(4);
    check("busy_after_fill", busy, 1);
    eval_tail(8'sd42);
    wait_done();
    check("result_latency", rise_cyc - e_cyc, 7);
`ifdef NEURON_FEEDER_REUSE_EN
    check("load_ready_after_done", load_ready, 0);
`else
    check("load_ready_after_done", load_ready, 1);
`endif

    // backpressure in DONE with loads offered meanwhile
    do_clear();
    result_ready = 1'b0;
    ld_x = '{8'sd10, -8'sd5, 8'sd0, 8'sd127};
    ld_w = '{-8'sd3, 8'sd7, 8'sd1, 8'sh80};
    load_pairs(4);
    eval_tail(-8'sd17);
    wait_rv();
    y_i = 8'sd99;
    for (int k = 0; k < 5; k++) begin
      load_valid = 1'b1; load_x = 8'sd99; load_w = 8'sd99;
      tick();
      check("bp_result_hold", result, -17);
      check("bp_result_valid", result_valid, 1);
      check("bp_load_ready", load_ready, 0);
    end
    load_valid = 1'b0;
    result_ready = 1'b1;
    tick();
    wait_done();

    // clear after pair 1 is presented
    do_clear();
    ld_x = '{-8'sd1, 8'sd11, -8'sd20, 8'sd4};
    ld_w = '{-8'sd2, 8'sd12, 8'sd30, -8'sd4};
    load_pairs(2);
    tick();
    tick();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    check("clr_mac_valid", mac_valid_o, 0);
    check("clr_state", dbg_state, FILL);
    check("clr_load_ready", load_ready, 1);
    check("clr_x_o", x_o, 0);
    // clear wins over a simultaneous load
    clear = 1'b1; load_valid = 1'b1; load_x = 8'sd55; load_w = 8'sd55;
    tick();
    clear = 1'b0; load_valid = 1'b0;
    repeat (10) tick();
    check("clr_no_result", result_valid, 0);

    // async reset during DRAIN
    ld_x = '{8'sd2, 8'sd4, 8'sd6, 8'sd8};
    ld_w = '{8'sd3, 8'sd5, 8'sd7, 8'sd9};
    load_pairs(4);
    repeat (5) tick();
    check("pre_rst_drain", dbg_state, DRAIN);
    #2 rst = 1'b0;
    #1;
    check("arst_mac_valid", mac_valid_o, 0);
    check("arst_result_valid", result_valid, 0);
    check("arst_load_ready", load_ready, 1);
    check("arst_busy", busy, 0);
    check("arst_state", dbg_state, FILL);
    @(posedge clk); #1;
    rst = 1'b1;
    tick();
    ld_x = '{-8'sd3, 8'sd100, 8'sd0, 8'sh80};
    ld_w = '{8'sd3, -8'sd1, 8'sd0, 8'sh80};
    load_pairs(4);
    eval_tail(8'sd5);
    wait_done();
    check("post_rst_latency", rise_cyc - e_cyc, 7);

    // replay / start handling
`ifdef NEURON_FEEDER_REUSE_EN
    check("reuse_load_ready", load_ready, 0);
    load_valid = 1'b1; load_x = 8'sd77; load_w = 8'sd77;
    repeat (2) tick();
    check("reuse_ignore_load", load_ready, 0);
    check("reuse_idle", busy, 0);
    load_valid = 1'b0;
    push_pairs(4);
    start = 1'b1;
    tick();
    start = 1'b0;
    e_cyc = cyc;
    eval_tail(-8'sd66);
    wait_done();
    check("replay_latency", rise_cyc - e_cyc, 7);
    do_clear();
    check("reuse_clear_ready", load_ready, 1);
`else
    check("noreuse_load_ready", load_ready, 1);
    start = 1'b1;
    tick();
    start = 1'b0;
    check("start_ignored_busy", busy, 0);
    check("start_ignored_state", dbg_state, FILL);
    repeat (3) tick();
    check("start_ignored_valid", mac_valid_o, 0);
`endif

    // single-pair build
    ld_valid1 = 1'b1; x1 = 8'sh80; w1 = 8'sd127;
    check("one_load_ready", ld_ready1, 1);
    tick();
    ld_valid1 = 1'b0;
    check("one_busy", busy1, 1);
    tick();
    check("one_mac_valid", mv1, 1);
    check("one_mac_clr", mc1, 1);
    check("one_x", xo1, -128);
    check("one_w", wo1, 127);
    y1 = -8'sd9;
    tick();
    check("one_stream_end", mv1, 0);
    tick();
    check("one_rv_early", rv1, 0);
    tick();
    check("one_rv", rv1, 1);
    check("one_result", res1, -9);
    tick();
    check("one_rv_drop", rv1, 0);

    tick();
    check("pairs_left", exp_q.size(), 0);
    check("results_left", exp_res_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
